// File: rtl/amiga_trigger_pkg.sv
// Shared definitions for the AMIGA trigger link: codeword geometry, receiver
// state encoding, Hamming position map and the transmitter's SECDED encoder.
package amiga_trigger_pkg;

    localparam int LTS_LEN  = 16;
    localparam int CODE_LEN = 22;
    localparam int PAR_LEN  = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        DECODE = 2'd2
    } rx_state_t;

    // Bit index (position - 1) of each data bit d0..d15 inside the codeword.
    localparam logic [4:0] DATA_IDX [LTS_LEN] = '{
        5'd2,  5'd4,  5'd5,  5'd6,
        5'd8,  5'd9,  5'd10, 5'd11, 5'd12, 5'd13, 5'd14,
        5'd16, 5'd17, 5'd18, 5'd19, 5'd20
    };

    // Bit index of each Hamming parity bit P1, P2, P4, P8, P16.
    localparam logic [4:0] PAR_IDX [PAR_LEN] = '{
        5'd0, 5'd1, 5'd3, 5'd7, 5'd15
    };

    // Bit index of the overall parity bit covering bits 20:0.
    localparam int OVERALL_IDX = CODE_LEN - 1;

    // SECDED encoder: place data, set each Pk so the syndrome of the
    // finished word is zero, then append overall even parity.
    function automatic logic [CODE_LEN-1:0] hamming_encode(input logic [LTS_LEN-1:0] lts);
        logic [CODE_LEN-1:0] code;
        logic [4:0]          syn;
        code = '0;
        for (int j = 0; j < LTS_LEN; j++) begin
            code[DATA_IDX[j]] = lts[j];
        end
        syn = '0;
        for (int i = 0; i < CODE_LEN - 1; i++) begin
            if (code[i]) begin
                syn = syn ^ 5'(i + 1);
            end
        end
        for (int k = 0; k < PAR_LEN; k++) begin
            code[PAR_IDX[k]] = syn[k];
        end
        code[OVERALL_IDX] = ^code[CODE_LEN-2:0];
        return code;
    endfunction

endpackage

// File: rtl/amiga_hamming_decoder.sv
// Combinational SECDED decoder for one 22-bit trigger codeword: computes the
// syndrome and overall parity, repairs a single flipped bit and extracts LTS.
module amiga_hamming_decoder
    import amiga_trigger_pkg::*;
(
    input  logic [CODE_LEN-1:0] code,
    output logic [LTS_LEN-1:0]  data,
    output logic                corrected,
    output logic                uncorrectable
);

    logic [4:0]          syndrome;
    logic                parity;
    logic [CODE_LEN-1:0] fixed;

    // Syndrome/parity evaluation, single-bit repair and data extraction.
    always_comb begin
        syndrome      = '0;
        parity        = ^code;
        fixed         = code;
        corrected     = 1'b0;
        uncorrectable = 1'b0;
        data          = '0;

        for (int i = 0; i < CODE_LEN - 1; i++) begin
            if (code[i]) begin
                syndrome = syndrome ^ 5'(i + 1);
            end
        end

        if (syndrome == 5'd0) begin
            // Only the overall parity bit can be wrong here; data is intact.
            corrected = parity;
        end else if (parity && (syndrome <= 5'(CODE_LEN - 1))) begin
            fixed[syndrome - 5'd1] = ~fixed[syndrome - 5'd1];
            corrected              = 1'b1;
        end else begin
            // Even parity with a non-zero syndrome, or a syndrome pointing
            // outside the word: at least two bits are wrong.
            uncorrectable = 1'b1;
        end

        for (int j = 0; j < LTS_LEN; j++) begin
            data[j] = fixed[DATA_IDX[j]];
        end
    end

endmodule

// File: rtl/amiga_trigger_rx.sv
// AMIGA trigger link receiver: synchronises the serial clock/data pair,
// deserialises 22-bit SECDED codewords, times out stalled frames and presents
// the decoded LTS with a one-cycle valid strobe.
module amiga_trigger_rx
    import amiga_trigger_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic               clock_120M,
    input  logic               reset,
    input  logic               clock_in,
    input  logic               lts_in,
    output logic [LTS_LEN-1:0] lts_out,
    output logic               valid,
    output logic               corrected,
    output logic               uncorrectable,
    output logic               frame_error,
    output logic               busy
);

    localparam int                IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);
    localparam logic [4:0]        LAST_BIT  = 5'(CODE_LEN - 1);

    logic                clk_p0, clk_p1, clk_p2;
    logic                dat_p0, dat_p1;
    logic                rise;

    rx_state_t           state;
    logic [CODE_LEN-1:0] shift_reg;
    logic [4:0]          bit_cnt;
    logic [IDLE_W-1:0]   idle_cnt;

    logic [LTS_LEN-1:0]  dec_data;
    logic                dec_corrected;
    logic                dec_uncorrectable;

    // Two-flop synchronisers on clock and data plus one delay flop on the
    // synchronised clock for edge detection.
    always_ff @(posedge clock_120M or posedge reset) begin
        if (reset) begin
            clk_p0 <= 1'b0;
            clk_p1 <= 1'b0;
            clk_p2 <= 1'b0;
            dat_p0 <= 1'b0;
            dat_p1 <= 1'b0;
        end else begin
            clk_p0 <= clock_in;
            clk_p1 <= clk_p0;
            clk_p2 <= clk_p1;
            dat_p0 <= lts_in;
            dat_p1 <= dat_p0;
        end
    end

    assign rise = clk_p1 & ~clk_p2;

    amiga_hamming_decoder u_decoder (
        .code          (shift_reg),
        .data          (dec_data),
        .corrected     (dec_corrected),
        .uncorrectable (dec_uncorrectable)
    );

    // Frame FSM: shift bits on each rise, time out stalled frames, and
    // register the decoder result for one valid cycle after the last bit.
    always_ff @(posedge clock_120M or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            shift_reg     <= '0;
            bit_cnt       <= '0;
            idle_cnt      <= '0;
            lts_out       <= '0;
            valid         <= 1'b0;
            corrected     <= 1'b0;
            uncorrectable <= 1'b0;
            frame_error   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            valid       <= 1'b0;
            frame_error <= 1'b0;

            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    busy    <= 1'b0;
                    if (rise) begin
                        shift_reg <= {shift_reg[CODE_LEN-2:0], dat_p1};
                        bit_cnt   <= 5'd1;
                        idle_cnt  <= '0;
                        busy      <= 1'b1;
                        state     <= RECV;
                    end
                end

                RECV: begin
                    if (rise) begin
                        shift_reg <= {shift_reg[CODE_LEN-2:0], dat_p1};
                        bit_cnt   <= bit_cnt + 5'd1;
                        idle_cnt  <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            busy  <= 1'b0;
                            state <= DECODE;
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        idle_cnt    <= IDLE_MAX;
                        frame_error <= 1'b1;
                        bit_cnt     <= '0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else if (idle_cnt != IDLE_MAX) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end

                DECODE: begin
                    lts_out       <= dec_data;
                    corrected     <= dec_corrected;
                    uncorrectable <= dec_uncorrectable;
                    valid         <= 1'b1;
                    bit_cnt       <= '0;
                    state         <= IDLE;
                    // A rise landing in this cycle already starts the next frame.
                    if (rise) begin
                        shift_reg <= {shift_reg[CODE_LEN-2:0], dat_p1};
                        bit_cnt   <= 5'd1;
                        idle_cnt  <= '0;
                        busy      <= 1'b1;
                        state     <= RECV;
                    end
                end

                default: begin
                    bit_cnt <= '0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_amiga_trigger_rx.sv
// Bench for amiga_trigger_rx: directed link scenarios plus randomised frames
// with injected bit errors, checked against a position-level SECDED model.
module tb_amiga_trigger_rx;
    import amiga_trigger_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        clock_in;
    logic        lts_in;
    logic [15:0] lts_out;
    logic        valid, corrected, uncorrectable, frame_error, busy;

    int vectors    = 0;
    int miscompares = 0;

    int valid_cnt = 0;
    int ferr_cnt  = 0;
    int both_cnt  = 0;
    int long_cnt  = 0;
    logic        prev_valid = 1'b0;
    logic [15:0] cap_lts = '0;
    logic        cap_c = 1'b0;
    logic        cap_u = 1'b0;

    always #4 clk = ~clk;

    amiga_trigger_rx #(.TIMEOUT(64)) dut (
        .clock_120M    (clk),
        .reset         (rst),
        .clock_in      (clock_in),
        .lts_in        (lts_in),
        .lts_out       (lts_out),
        .valid         (valid),
        .corrected     (corrected),
        .uncorrectable (uncorrectable),
        .frame_error   (frame_error),
        .busy          (busy)
    );

    // Strobe monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (valid) begin
            valid_cnt = valid_cnt + 1;
            cap_lts   = lts_out;
            cap_c     = corrected;
            cap_u     = uncorrectable;
        end
        if (frame_error) ferr_cnt = ferr_cnt + 1;
        if (valid && frame_error) both_cnt = both_cnt + 1;
        if (valid && prev_valid) long_cnt = long_cnt + 1;
        prev_valid = valid;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors = vectors + 1;
        if (got !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Positions 1..21 that are not powers of two carry data, in ascending order.
    function automatic bit is_data_pos(input int pos);
        return (pos & (pos - 1)) != 0;
    endfunction

    function automatic logic [21:0] model_encode(input logic [15:0] d);
        logic [21:0] c;
        int j;
        c = '0;
        j = 0;
        for (int pos = 1; pos <= 21; pos++) begin
            if (is_data_pos(pos)) begin
                c[pos-1] = d[j];
                j++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            logic p;
            p = 1'b0;
            for (int pos = 1; pos <= 21; pos++) begin
                if (is_data_pos(pos) && ((pos >> k) & 1) == 1) p = p ^ c[pos-1];
            end
            c[(1 << k) - 1] = p;
        end
        c[21] = ^c[20:0];
        return c;
    endfunction

    function automatic logic [15:0] model_extract(input logic [21:0] c);
        logic [15:0] d;
        int j;
        d = '0;
        j = 0;
        for (int pos = 1; pos <= 21; pos++) begin
            if (is_data_pos(pos)) begin
                d[j] = c[pos-1];
                j++;
            end
        end
        return d;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Transmit the first nbits of a codeword, bit 21 first, 12-cycle bit period.
    task automatic send_bits(input logic [21:0] code, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            lts_in = code[21-i];
            wait_cycles(6);
            clock_in = 1'b1;
            wait_cycles(6);
            clock_in = 1'b0;
        end
    endtask

    task automatic run_frame(input string tag, input logic [21:0] code,
                             input logic [15:0] exp_lts, input logic exp_c, input logic exp_u);
        int v0, f0;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_bits(code, 22);
        wait_cycles(8);
        check_eq({tag, "_valid"}, 32'(valid_cnt - v0), 32'd1);
        check_eq({tag, "_ferr"}, 32'(ferr_cnt - f0), 32'd0);
        check_eq({tag, "_lts"}, 32'(cap_lts), 32'(exp_lts));
        check_eq({tag, "_corr"}, 32'(cap_c), 32'(exp_c));
        check_eq({tag, "_unc"}, 32'(cap_u), 32'(exp_u));
        check_eq({tag, "_hold"}, {15'd0, uncorrectable, corrected, lts_out},
                 {15'd0, exp_u, exp_c, exp_lts});
    endtask

    initial begin
        int v0, f0;
        rst      = 1'b1;
        clock_in = 1'b0;
        lts_in   = 1'b0;
        wait_cycles(3);
        @(negedge clk);
        check_eq("rst_lts", 32'(lts_out), 32'd0);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_corr", 32'(corrected), 32'd0);
        check_eq("rst_unc", 32'(uncorrectable), 32'd0);
        check_eq("rst_ferr", 32'(frame_error), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_cycles(4);

        check_eq("enc_ffff", 32'(hamming_encode(16'hFFFF)), 32'h1FFFFE);
        check_eq("enc_0000", 32'(hamming_encode(16'h0000)), 32'h0);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            check_eq("enc_rand", 32'(hamming_encode(d)), 32'(model_encode(d)));
        end

        run_frame("zero", 22'h000000, 16'h0000, 1'b0, 1'b0);
        run_frame("ones", 22'h1FFFFE, 16'hFFFF, 1'b0, 1'b0);
        run_frame("fix_d2", 22'h1FFFDE, 16'hFFFF, 1'b1, 1'b0);
        run_frame("fix_p", 22'h3FFFFE, 16'hFFFF, 1'b1, 1'b0);
        run_frame("dbl", 22'h1FFFFD, 16'hFFFF, 1'b0, 1'b1);

        // Stalled frame: 10 bits then silence beyond the timeout.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_bits(22'h2AAAAA, 10);
        check_eq("to_busy_mid", 32'(busy), 32'd1);
        wait_cycles(80);
        check_eq("to_ferr", 32'(ferr_cnt - f0), 32'd1);
        check_eq("to_novalid", 32'(valid_cnt - v0), 32'd0);
        check_eq("to_busy", 32'(busy), 32'd0);
        run_frame("after_to", 22'h1FFFFE, 16'hFFFF, 1'b0, 1'b0);

        // Reset in the middle of a frame.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_bits(22'h3FFFFF, 15);
        check_eq("rm_busy_mid", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rm_busy", 32'(busy), 32'd0);
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(80);
        check_eq("rm_nostrobe", 32'((valid_cnt - v0) + (ferr_cnt - f0)), 32'd0);
        run_frame("after_rst", 22'h000000, 16'h0000, 1'b0, 1'b0);

        // Randomised frames with 0, 1 or 2 flipped bits.
        for (int n = 0; n < 30; n++) begin
            logic [15:0] d;
            logic [21:0] cw;
            int kind, a, b;
            d    = 16'($urandom);
            cw   = model_encode(d);
            kind = $urandom_range(0, 2);
            a    = $urandom_range(0, 21);
            b    = (a + $urandom_range(1, 21)) % 22;
            if (kind >= 1) cw[a] = ~cw[a];
            if (kind == 2) cw[b] = ~cw[b];
            if (kind == 0)      run_frame("rnd_clean", cw, d, 1'b0, 1'b0);
            else if (kind == 1) run_frame("rnd_single", cw, d, 1'b1, 1'b0);
            else                run_frame("rnd_double", cw, model_extract(cw), 1'b0, 1'b1);
        end

        check_eq("strobe_excl", 32'(both_cnt), 32'd0);
        check_eq("valid_1cyc", 32'(long_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
